// File: rtl/uart_text_writer.sv
// uart_text_writer: turns received UART bytes into character-RAM writes for a
// scrolling text console. Handles the CR, LF, BS and FF control codes and wraps
// printable characters at the end of a row. Scrolling rotates a row offset, so
// nothing is ever copied in RAM. After reset the whole buffer is cleared.
module uart_text_writer #(
    parameter int         COLS       = 128,
    parameter int         ROWS       = 48,
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    localparam int        ADDR_W     = $clog2(COLS * ROWS),
    localparam int        COL_W      = $clog2(COLS),
    localparam int        ROW_W      = $clog2(ROWS)
) (
    input  logic              clockIN,
    input  logic              nRxResetIN,
    input  logic              rxReadyIN,
    input  logic [7:0]        rxDataIN,
    output logic              wrEnOUT,
    output logic [ADDR_W-1:0] wrAddrOUT,
    output logic [7:0]        wrDataOUT,
    output logic [COL_W-1:0]  cursorColOUT,
    output logic [ROW_W-1:0]  cursorRowOUT,
    output logic [ROW_W-1:0]  scrollRowOUT,
    output logic              busyOUT,
    output logic              overrunOUT
);

    localparam logic [ADDR_W-1:0] ALL_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_END  = ADDR_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]    ROWS_V   = (ROW_W + 1)'(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_t;

    state_t            state, state_nxt;
    logic              sync1, sync2, sync2_d;
    logic              rise;
    logic              pend_valid;
    logic [7:0]        pend_data;
    logic              consume;
    logic              do_newline;
    logic [COL_W-1:0]  col, col_nxt, col_dec;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [ROW_W-1:0]  scroll, scroll_nxt;
    logic [ROW_W-1:0]  clr_row, clr_row_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        data_nxt;

    // Physical RAM row for a logical row, given the current scroll offset.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] r,
                                                  input logic [ROW_W-1:0] s);
        logic [ROW_W:0] sum;
        sum = {1'b0, r} + {1'b0, s};
        if (sum >= ROWS_V)
            sum = sum - ROWS_V;
        return sum[ROW_W-1:0];
    endfunction

    // RAM address of a (physical row, column) pair, computed at full address width.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] p,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(p) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    assign rise         = sync2 & ~sync2_d;
    assign col_dec      = col - 1'b1;
    assign cursorColOUT = col;
    assign cursorRowOUT = row;
    assign scrollRowOUT = scroll;

    // Synchronise the ready level, catch its rising edge, and hold one pending byte.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync2_d    <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            overrunOUT <= 1'b0;
        end else begin
            sync1   <= rxReadyIN;
            sync2   <= sync1;
            sync2_d <= sync2;
            if (rise) begin
                if (pend_valid && !consume) begin
                    overrunOUT <= 1'b1;
                end else begin
                    pend_data  <= rxDataIN;
                    pend_valid <= 1'b1;
                end
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Register FSM state, cursor/scroll and the RAM write port.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            state     <= CLEAR_ALL;
            col       <= '0;
            row       <= '0;
            scroll    <= '0;
            clr_row   <= '0;
            clr_cnt   <= '0;
            wrEnOUT   <= 1'b0;
            wrAddrOUT <= '0;
            wrDataOUT <= '0;
            busyOUT   <= 1'b1;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            scroll    <= scroll_nxt;
            clr_row   <= clr_row_nxt;
            clr_cnt   <= clr_cnt_nxt;
            wrEnOUT   <= wr_en_nxt;
            wrAddrOUT <= addr_nxt;
            wrDataOUT <= data_nxt;
            // The state register leaves a clear one cycle before its last write
            // appears, so busy also covers the cycle after any non-IDLE state.
            busyOUT   <= (state != IDLE) || (state_nxt != IDLE);
        end
    end

    // Next-state logic: dispatch pending bytes in IDLE, step through clears otherwise.
    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        scroll_nxt  = scroll;
        clr_row_nxt = clr_row;
        clr_cnt_nxt = clr_cnt;
        wr_en_nxt   = 1'b0;
        addr_nxt    = wrAddrOUT;
        data_nxt    = wrDataOUT;
        consume     = 1'b0;
        do_newline  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    consume = 1'b1;
                    if (pend_data >= 8'h20 && pend_data <= 8'h7E) begin
                        wr_en_nxt = 1'b1;
                        addr_nxt  = cell_addr(phys_row(row, scroll), col);
                        data_nxt  = pend_data;
                        if (col == COL_LAST) begin
                            col_nxt    = '0;
                            do_newline = 1'b1;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end else begin
                        case (pend_data)
                            8'h0D: col_nxt = '0;
                            8'h0A: do_newline = 1'b1;
                            8'h08: begin
                                if (col != '0) begin
                                    col_nxt   = col_dec;
                                    wr_en_nxt = 1'b1;
                                    addr_nxt  = cell_addr(phys_row(row, scroll), col_dec);
                                    data_nxt  = CLEAR_CHAR;
                                end
                            end
                            8'h0C: begin
                                col_nxt     = '0;
                                row_nxt     = '0;
                                scroll_nxt  = '0;
                                clr_cnt_nxt = '0;
                                state_nxt   = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                    // On the bottom line the old top row becomes the new bottom row.
                    if (do_newline) begin
                        if (row != ROW_LAST) begin
                            row_nxt = row + 1'b1;
                        end else begin
                            scroll_nxt  = (scroll == ROW_LAST) ? '0 : scroll + 1'b1;
                            clr_row_nxt = scroll;
                            clr_cnt_nxt = '0;
                            state_nxt   = CLEAR_ROW;
                        end
                    end
                end
            end
            CLEAR_ROW: begin
                wr_en_nxt   = 1'b1;
                addr_nxt    = cell_addr(clr_row, clr_cnt[COL_W-1:0]);
                data_nxt    = CLEAR_CHAR;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == ROW_END)
                    state_nxt = IDLE;
            end
            CLEAR_ALL: begin
                wr_en_nxt   = 1'b1;
                addr_nxt    = clr_cnt;
                data_nxt    = CLEAR_CHAR;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == ALL_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
